// File: rtl/round_seq_pkg.sv
// Shared types and constants for the round sequencer.
// Widths, last-round indices and FSM state encoding.
package round_seq_pkg;

  localparam int DATA_W        = 136;
  localparam int CNT_W         = 4;
  localparam int LAST_ROUND_M0 = 10;
  localparam int LAST_ROUND_M1 = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/round_seq_counter.sv
// Round index register with saturating compare against the last round.
// hit marks count==last; inc never advances past last.
module round_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         hit,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit   = (cnt_q == last);
  assign count = cnt_q;

endmodule

// File: rtl/round_seq.sv
// Iterative round sequencer: loads a word, feeds it through an external
// round selector 11 or 15 times, then hands the result downstream.
module round_seq
  import round_seq_pkg::*;
#(
  parameter int DATA_W = round_seq_pkg::DATA_W,
  parameter int CNT_W  = round_seq_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  input  logic              abort,
  output logic [DATA_W-1:0] state_q,
  input  logic [DATA_W-1:0] round_data,
  output logic [CNT_W-1:0]  counter,
  output logic              mux_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  last_q;
  logic              accept;
  logic              clr;
  logic              inc;
  logic              hit;

  assign accept = (state == IDLE) && in_valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid)  next_state = RUN;
        RUN:     if (hit)       next_state = DONE;
        DONE:    if (out_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    mux_flag  = (state == RUN) && hit;
  end

  // Mode is captured only at accept so later toggles cannot shorten a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= CNT_W'(LAST_ROUND_M0);
    end else if (accept) begin
      last_q <= mode ? CNT_W'(LAST_ROUND_M1)
                     : CNT_W'(LAST_ROUND_M0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (accept) begin
      state_q <= in_data;
    end else if (state == RUN && !abort) begin
      state_q <= round_data;
    end
  end

  always_comb begin
    clr = abort || (state == IDLE) ||
          (state == DONE && out_ready);
    inc = (state == RUN) && !abort;
  end

  round_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (inc),
    .last (last_q),
    .hit  (hit),
    .count(counter)
  );

  assign out_data = state_q;

endmodule

// File: tb/tb_round_seq.sv
// Directed bench for round_seq with an increment-by-one round selector.
// Expected values are hand-derived constants and loop indices.
module tb_round_seq;

  localparam int DW = 136;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          mode;
  logic          abort;
  logic [DW-1:0] state_q;
  logic [DW-1:0] round_data;
  logic [CW-1:0] counter;
  logic          mux_flag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [DW-1:0] D0 =
    136'h01_0123456789abcdef_0123456789abcdef;
  localparam logic [DW-1:0] D1 =
    136'hff_fedcba9876543210_fedcba9876543210;

  round_seq #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .abort     (abort),
    .state_q   (state_q),
    .round_data(round_data),
    .counter   (counter),
    .mux_flag  (mux_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  assign round_data = state_q + 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_rdy"}, DW'(in_ready), DW'(1));
    chk({tag, "_cnt"}, DW'(counter), DW'(0));
    chk({tag, "_mux"}, DW'(mux_flag), DW'(0));
    chk({tag, "_ov"}, DW'(out_valid), DW'(0));
  endtask

  logic [DW-1:0] held;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #3;
    chk_idle("rst");
    chk("rst_sq", state_q, '0);
    #1;
    rst_n = 1'b1;

    // mode 0 run; in_valid and mode toggled mid-run must be ignored
    in_valid = 1'b1;
    in_data  = D0;
    mode     = 1'b0;
    step();
    in_data = D1;
    mode    = 1'b1;
    chk("m0_acc_busy", DW'(busy), DW'(1));
    chk("m0_acc_rdy", DW'(in_ready), DW'(0));
    chk("m0_acc_cnt", DW'(counter), DW'(0));
    chk("m0_acc_sq", state_q, D0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("m0_cnt%0d", k), DW'(counter), DW'(k));
      chk($sformatf("m0_mux%0d", k), DW'(mux_flag),
          DW'(k == 10));
      chk($sformatf("m0_ov%0d", k), DW'(out_valid), DW'(0));
      chk($sformatf("m0_sq%0d", k), state_q, D0 + DW'(k));
    end
    in_valid = 1'b0;
    step();
    chk("m0_ov", DW'(out_valid), DW'(1));
    chk("m0_od", out_data, D0 + DW'(11));
    chk("m0_done_cnt", DW'(counter), DW'(10));
    chk("m0_done_mux", DW'(mux_flag), DW'(0));
    chk("m0_done_rdy", DW'(in_ready), DW'(0));

    // backpressure: hold in DONE for 5 cycles
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp_ov%0d", k), DW'(out_valid), DW'(1));
      chk($sformatf("bp_od%0d", k), out_data, D0 + DW'(11));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_idle("m0_end");

    // mode 1 run
    in_valid = 1'b1;
    in_data  = D0;
    mode     = 1'b1;
    step();
    in_valid = 1'b0;
    mode     = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("m1_cnt%0d", k), DW'(counter), DW'(k));
      chk($sformatf("m1_mux%0d", k), DW'(mux_flag),
          DW'(k == 14));
      chk($sformatf("m1_ov%0d", k), DW'(out_valid), DW'(0));
    end
    step();
    chk("m1_ov", DW'(out_valid), DW'(1));
    chk("m1_od", out_data, D0 + DW'(15));
    chk("m1_cnt_sat", DW'(counter), DW'(14));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_idle("m1_end");

    // abort at counter 6 with a competing in_valid
    in_valid = 1'b1;
    in_data  = D1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    chk("ab_pre_cnt", DW'(counter), DW'(6));
    held     = D1 + DW'(6);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = D0;
    step();
    chk_idle("ab");
    chk("ab_sq_hold", state_q, held);
    abort    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_idle("ab_post");
    chk("ab_post_sq", state_q, held);

    // async reset mid-clock at counter 3
    in_valid = 1'b1;
    in_data  = D0;
    mode     = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    chk("ar_pre_cnt", DW'(counter), DW'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("ar");
    chk("ar_sq", state_q, '0);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = D1;
    step();
    in_valid = 1'b0;
    chk("ar_acc_busy", DW'(busy), DW'(1));
    chk("ar_acc_sq", state_q, D1);
    chk("ar_acc_cnt", DW'(counter), DW'(0));
    step();
    chk("ar_run_cnt", DW'(counter), DW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
